// File: rtl/axi_lite_imem_slave_pkg.sv
// Shared definitions for the instruction-memory AXI-lite read responder:
// bus widths, response codes, FSM encoding and the latency reload helper.
package axi_lite_imem_slave_pkg;

    localparam int IMEM_ADDR_W = 32;
    localparam int IMEM_DATA_W = 64;
    localparam int LAT_W       = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } imem_state_e;

    // The counter reaching zero is itself one wait cycle, so it is loaded
    // with one less than the requested extra latency.
    function automatic logic [LAT_W-1:0] lat_reload(input int latency);
        return (latency > 0) ? LAT_W'(latency - 1) : '0;
    endfunction

endpackage

// File: rtl/axi_lite_imem_slave_if.sv
// AR/R read-channel bundle between the IFU (master) and the imem responder.
interface axi_lite_imem_slave_if
    import axi_lite_imem_slave_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
);

    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic              arready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rready;

    modport master (
        output arvalid,
        output araddr,
        output rready,
        input  arready,
        input  rvalid,
        input  rdata,
        input  rresp
    );

    modport slave (
        input  arvalid,
        input  araddr,
        input  rready,
        output arready,
        output rvalid,
        output rdata,
        output rresp
    );

endinterface

// File: rtl/imem_lat_counter.sv
// Loadable down-counter with a zero flag, used to pad response latency.
// Decrement saturates at zero so a late decrement request is harmless.
module imem_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/axi_lite_imem_slave.sv
// AXI-lite read responder for instruction fetches. One request in flight;
// in-range addresses read the synchronous imem SRAM, out-of-range addresses
// answer SLVERR with zero data. Extra response latency is a build parameter.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for an address, ARREADY=1
// READ    | SRAM data arriving this cycle, captured into RDATA
// WAIT    | padding cycles counted down by the latency counter
// RESP    | RVALID=1, response held until RREADY; may accept next address
module axi_lite_imem_slave
    import axi_lite_imem_slave_pkg::*;
#(
    parameter int                ADDR_W  = IMEM_ADDR_W,
    parameter int                DATA_W  = IMEM_DATA_W,
    parameter int                LATENCY = 0,
    parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] SIZE    = 32'h0800_0000
) (
    input  logic                clk,
    input  logic                rst,
    axi_lite_imem_slave_if.slave bus,
    output logic                mem_en,
    output logic [ADDR_W-4:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [LAT_W-1:0] LAT_LOAD = lat_reload(LATENCY);

    imem_state_e       state;
    imem_state_e       state_nxt;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic [ADDR_W-1:0] offset;
    logic              in_range;
    logic              arready_c;
    logic              accept;
    logic              capture_mem;
    logic              set_err;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;

    // Wrap-around subtraction makes addresses below BASE look huge, so a
    // single unsigned compare covers both ends of the window.
    assign offset   = bus.araddr - BASE;
    assign in_range = (offset < SIZE);
    assign mem_addr = offset[ADDR_W-1:3];

    // Next state and per-cycle controls; the address is only consumed in
    // the handshake cycle, which is why mem_en/mem_addr are combinational.
    always_comb begin
        state_nxt   = state;
        arready_c   = 1'b0;
        mem_en      = 1'b0;
        capture_mem = 1'b0;
        set_err     = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        accept      = 1'b0;
        case (state)
            ST_IDLE: begin
                arready_c = 1'b1;
            end
            ST_READ: begin
                capture_mem = 1'b1;
                if (LATENCY == 0) begin
                    state_nxt = ST_RESP;
                end else begin
                    cnt_load  = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                arready_c = bus.rready;
                if (bus.rready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        accept = bus.arvalid && arready_c;
        if (accept) begin
            if (in_range) begin
                mem_en    = 1'b1;
                state_nxt = ST_READ;
            end else begin
                set_err   = 1'b1;
                state_nxt = ST_RESP;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response payload: error loaded at accept, SRAM data one cycle after mem_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (set_err) begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
        end else if (capture_mem) begin
            rdata_q <= mem_rdata;
            rresp_q <= RESP_OKAY;
        end
    end

    imem_lat_counter #(
        .W (LAT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign bus.arready = arready_c;
    assign bus.rvalid  = (state == ST_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_imem_slave.sv
// Bench for the imem read responder: a zero-latency instance under directed
// then random traffic against a transaction-level model and scoreboard, plus
// a three-cycle-latency instance exercised with directed timing/reset cases.
`timescale 1ns/1ps
module tb_axi_lite_imem_slave;
    import axi_lite_imem_slave_pkg::*;

    localparam int          AW    = 32;
    localparam int          DW    = 64;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] SIZE  = 32'h0800_0000;
    localparam int          LAT_B = 3;
    localparam int          NDIR  = 16;
    localparam int          NRAND = 600;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
    } rsp_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    always #5 clk = ~clk;

    axi_lite_imem_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    axi_lite_imem_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    logic          mem_en0, mem_en1;
    logic [AW-4:0] mem_addr0, mem_addr1;
    logic [DW-1:0] mem_rdata0, mem_rdata1;

    axi_lite_imem_slave #(
        .ADDR_W(AW), .DATA_W(DW), .LATENCY(0), .BASE(BASE), .SIZE(SIZE)
    ) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0),
        .mem_en(mem_en0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0)
    );

    axi_lite_imem_slave #(
        .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT_B), .BASE(BASE), .SIZE(SIZE)
    ) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1),
        .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_rdata(mem_rdata1)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Memory contents as a pure function of the word index.
    function automatic logic [63:0] word_at(input logic [31:0] idx);
        return {32'h0000_0013 ^ (idx * 32'h9E37_79B9), 32'h0000_0093 + idx * 32'h0101_0101};
    endfunction

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + SIZE);
    endfunction

    function automatic logic [31:0] idx_of(input logic [31:0] a);
        return (a - BASE) >> 3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous-read SRAM models; junk when not enabled so stale capture shows.
    always @(posedge clk) begin
        mem_rdata0 <= mem_en0 ? word_at({3'b000, mem_addr0}) : {$urandom, $urandom};
        mem_rdata1 <= mem_en1 ? word_at({3'b000, mem_addr1}) : {$urandom, $urandom};
    end

    // Reference model outputs for DUT0, written by the driver each cycle.
    bit          run0 = 1'b0;
    bit          e_arready, e_rvalid, e_mem_en;
    logic [28:0] e_mem_addr;
    rsp_t        exp_q[$];
    rsp_t        e_rsp;

    task automatic pick_directed(input int c, output logic av, output logic [31:0] ad, output logic rr);
        av = 1'b1; rr = 1'b1; ad = 32'h0;
        case (c)
            0:       ad = 32'h8000_0000;
            1, 2:    ad = 32'h8000_0008;
            3:       ad = 32'h8000_0010;
            4:       begin ad = 32'h8000_0010; rr = 1'b0; end
            5, 6, 7, 8: begin ad = 32'h7FFF_FFFC; rr = 1'b0; end
            9:       ad = 32'h7FFF_FFFC;
            10:      ad = 32'h8800_0000;
            11, 13, 14: av = 1'b0;
            12:      ad = 32'h87FF_FFF8;
            default: ad = 32'h8000_0004;
        endcase
    endtask

    task automatic pick_random(output logic av, output logic [31:0] ad, output logic rr);
        av = ($urandom_range(0, 3) != 0);
        rr = ($urandom_range(0, 4) != 0);
        case ($urandom_range(0, 7))
            0:       ad = BASE - 32'($urandom_range(1, 64));
            1:       ad = BASE + SIZE + 32'($urandom_range(0, 64));
            2:       ad = BASE + SIZE - 32'($urandom_range(1, 8));
            3:       ad = $urandom;
            default: ad = BASE + ($urandom & (SIZE - 1));
        endcase
    endtask

    // DUT0 driver: applies stimulus and advances the transaction-level model.
    task automatic run_dut0();
        logic        av, rr;
        logic [31:0] ad, ix;
        bit          outstanding, hs, r_hs, inr;
        int          ready_at;
        outstanding = 1'b0;
        ready_at    = 0;
        for (int c = 0; c < NDIR + NRAND + 8; c++) begin
            @(posedge clk); #1;
            if (c < NDIR) pick_directed(c, av, ad, rr);
            else if (c < NDIR + NRAND) pick_random(av, ad, rr);
            else begin av = 1'b0; ad = 32'h0; rr = 1'b1; end
            inr        = in_win(ad);
            ix         = idx_of(ad);
            e_rvalid   = outstanding && (c >= ready_at);
            e_arready  = !outstanding || (e_rvalid && rr);
            hs         = av && e_arready;
            r_hs       = e_rvalid && rr;
            e_mem_en   = hs && inr;
            e_mem_addr = ix[28:0];
            bus0.arvalid = av;
            bus0.araddr  = ad;
            bus0.rready  = rr;
            if (r_hs) outstanding = 1'b0;
            if (hs) begin
                outstanding = 1'b1;
                ready_at    = c + (inr ? 2 : 1);
                if (inr) exp_q.push_back('{word_at(ix), RESP_OKAY});
                else     exp_q.push_back('{64'h0, RESP_SLVERR});
            end
            run0 = 1'b1;
        end
        @(negedge clk); #1;
        run0 = 1'b0;
    endtask

    // DUT0 monitor: per-cycle handshake checks and scoreboard pops on R beats.
    always @(negedge clk) begin
        if (run0) begin
            check("arready", bus0.arready, e_arready);
            check("rvalid", bus0.rvalid, e_rvalid);
            check("mem_en", mem_en0, e_mem_en);
            if (e_mem_en) check("mem_addr", mem_addr0, e_mem_addr);
            if (bus0.rvalid && bus0.rready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL r_beat: got unexpected response data %h, expected none", bus0.rdata);
                end else begin
                    e_rsp = exp_q.pop_front();
                    check("rdata", bus0.rdata, e_rsp.data);
                    check("rresp", bus0.rresp, e_rsp.resp);
                end
            end
        end
    end

    // DUT1: latency-3 timing, async reset mid-WAIT, recovery, out-of-range.
    task automatic run_dut1();
        int lat;
        @(posedge clk); #1;
        bus1.arvalid = 1'b1; bus1.araddr = BASE + 32'h18;
        @(negedge clk);
        check("b_mem_en_c0", mem_en1, 1);
        check("b_mem_addr_c0", mem_addr1, 3);
        check("b_arready_c0", bus1.arready, 1);
        @(posedge clk); #1;
        bus1.arvalid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("b_arready_wait", bus1.arready, 0);
            check("b_rvalid_wait", bus1.rvalid, 0);
        end
        @(negedge clk);
        check("b_rvalid_c5", bus1.rvalid, 1);
        check("b_rdata_c5", bus1.rdata, word_at(3));
        check("b_rresp_c5", bus1.rresp, RESP_OKAY);

        @(posedge clk); #1;
        bus1.arvalid = 1'b1; bus1.araddr = BASE + 32'h40;
        @(posedge clk); #1;
        bus1.arvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b_arready_in_wait", bus1.arready, 0);
        #2 rst1 = 1'b0;
        #1;
        check("b_rst_arready", bus1.arready, 1);
        check("b_rst_rvalid", bus1.rvalid, 0);
        check("b_rst_rdata", bus1.rdata, 64'h0);
        check("b_rst_rresp", bus1.rresp, RESP_OKAY);
        @(posedge clk);
        @(posedge clk); #2;
        rst1 = 1'b1;

        @(posedge clk); #1;
        bus1.arvalid = 1'b1; bus1.araddr = BASE + 32'h7FF0;
        @(negedge clk);
        check("b_mem_addr_after_rst", mem_addr1, 32'hFFE);
        @(posedge clk); #1;
        bus1.arvalid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus1.rvalid) begin
                lat = n;
                break;
            end
        end
        check("b_latency_after_rst", 64'(lat), 64'(2 + LAT_B));
        check("b_rdata_after_rst", bus1.rdata, word_at(32'hFFE));

        @(posedge clk); #1;
        bus1.arvalid = 1'b1; bus1.araddr = BASE - 32'h8;
        @(negedge clk);
        check("b_oor_mem_en", mem_en1, 0);
        @(posedge clk); #1;
        bus1.arvalid = 1'b0;
        @(negedge clk);
        check("b_oor_rvalid", bus1.rvalid, 1);
        check("b_oor_rresp", bus1.rresp, RESP_SLVERR);
        check("b_oor_rdata", bus1.rdata, 64'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst0 = 1'b0;
        rst1 = 1'b0;
        bus0.arvalid = 1'b0; bus0.araddr = 32'h0; bus0.rready = 1'b0;
        bus1.arvalid = 1'b0; bus1.araddr = 32'h0; bus1.rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", bus0.arready, 1);
        check("rst_rvalid", bus0.rvalid, 0);
        check("rst_rdata", bus0.rdata, 64'h0);
        check("rst_rresp", bus0.rresp, 2'b00);
        check("rst_mem_en", mem_en0, 0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        fork
            run_dut0();
            run_dut1();
        join
        check("drain_empty", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/axi_lite_imem_slave.md
Name: axi_lite_imem_slave

Overview:
- AXI-lite read-channel responder that serves instruction fetches from the IFU's AR/R master port.
- Accepts one read address, reads a 64-bit word from a synchronous-read instruction SRAM, and returns it on the R channel.
- Adds a programmable extra latency so IFU stall/back-pressure paths can be exercised.
- Out-of-range addresses return SLVERR with zero data.
- Sits between the IFU and the imem SRAM macro/model.

Parameters:
- ADDR_W, 32, AR address width (matches MemAddrBus).
- DATA_W, 64, R data width (matches MemDataBus).
- LATENCY, 0, extra wait cycles between SRAM read and RVALID (0..15).
- BASE, 32'h8000_0000, first valid byte address.
- SIZE, 32'h0800_0000, valid window size in bytes (power of two).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- ARVALID  in  1  read address valid.
- ARADDR  in  ADDR_W  byte address.
- ARREADY  out  1  address accepted when ARVALID&ARREADY.
- RVALID  out  1  read data valid.
- RDATA  out  DATA_W  aligned 64-bit word.
- RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- RREADY  in  1  master accepts data.
- mem_en  out  1  SRAM read enable, one-cycle pulse.
- mem_addr  out  ADDR_W-3  word index ((ARADDR-BASE)>>3).
- mem_rdata  in  DATA_W  SRAM data, valid the cycle after mem_en.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ARREADY=1, RVALID=0, RDATA=0, RRESP=0, mem_en=0, wait counter=0. Outputs hold these values until the first clk edge after rst returns to 1.
- FSM states: IDLE, READ, WAIT, RESP.
- IDLE:
  - ARREADY=1.
  - On ARVALID: latch ARADDR; in_range = (ARADDR-BASE) < SIZE, compared as unsigned ADDR_W-bit values.
  - If in range: mem_en=1 in the same cycle (combinational from ARVALID in IDLE), then go to READ.
  - If out of range: go to RESP directly with RDATA=0, RRESP=2'b10. No mem_en.
- READ:
  - Capture mem_rdata into the RDATA register.
  - LATENCY==0: go to RESP. Otherwise load counter with LATENCY-1 and go to WAIT.
- WAIT: decrement counter; go to RESP when counter==0.
- RESP:
  - RVALID=1. RDATA/RRESP stable until the handshake.
  - On RREADY: RVALID deasserts next cycle unless a new response is produced.
  - ARREADY = RREADY in this state.
  - If ARVALID&RREADY: accept the new address and issue mem_en this cycle, then go to READ (or to RESP again for an out-of-range address). Otherwise go to IDLE.
- Latency:
  - LATENCY=0: AR handshake cycle N gives RVALID at N+2.
  - In general RVALID is at N+2+LATENCY.
  - Sustained throughput is one beat per 2+LATENCY cycles.
- Alignment: ARADDR[2:0] is ignored; the full 64-bit word is returned and the master selects the half.
- Flush: there is no cancel. A master that drops ARVALID before the handshake simply causes no transaction. An accepted request always completes.
- ARADDR changes while ARVALID is high without a handshake: only the value at the handshake cycle is used.
- Reset mid-transaction: aborts immediately. Any pending response is lost and RVALID=0.
- Never more than one outstanding transaction. ARREADY is 0 in READ and WAIT.

Decomposition:
- Shared package/defines: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, FSM state encoding (2-bit), address/data widths taken from the existing width defines.
- One natural sub-module: imem_lat_counter (loadable down-counter with zero flag), reused later by the data-memory responder.

Test Plan:
- Single read, LATENCY=0, mem model returns 64'h0000_0013_0000_0093 for index 0: ARVALID with ARADDR=32'h8000_0000 in cycle 0 -> mem_en=1, mem_addr=0 in cycle 0; RVALID=1 with that RDATA and RRESP=0 in cycle 2.
- Back-to-back fetches, RREADY=1, ARVALID held, addresses 8000_0000 then 8000_0008 -> second AR accepted in the first RESP cycle; RVALID pulses every 2 cycles; data in order.
- Back-pressure: RREADY=0 for 5 cycles during RESP -> RVALID, RDATA and RRESP stay stable; ARREADY=0; no mem_en until RREADY=1.
- Out-of-range: ARADDR=32'h7FFF_FFFC and 32'h8800_0000 -> no mem_en; RVALID two cycles later... no: one cycle later (IDLE->RESP), with RRESP=2'b10 and RDATA=0.
- LATENCY=3 build: AR handshake at cycle 0 -> RVALID at cycle 5; ARREADY=0 during cycles 1-4.
- Async reset: drop rst to 0 mid-WAIT, between clock edges -> RVALID=0 and ARREADY=1 immediately; after release, a new read completes normally.
